// File: rtl/majority_vote_filter.sv
// N-input majority voter with HOLD-cycle persistence filter and saturating disagreement counter.
// Latency: in -> in_q 1 edge, y flips HOLD edges later; no backpressure, en=0 stalls all state.
module majority_vote_filter #(
   parameter int N    = 3,
   parameter int HOLD = 4,
   parameter int CW   = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          en,
   input  logic [N-1:0]  in,
   input  logic          clr_count,
   output logic          y,
   output logic          change,
   output logic          unanimous,
   output logic [CW-1:0] fault_count
);

   localparam int       PW      = $clog2(N + 1);
   localparam int       THR     = (N + 1) / 2;
   localparam bit [7:0] HOLD_M1 = 8'(HOLD - 1);

   logic [N-1:0]  in_q;
   logic [7:0]    stab;
   logic [PW-1:0] pop;
   logic          maj;
   logic          in_unan;

   always_comb begin
      pop = '0;
      for (int i = 0; i < N; i++) begin
         pop = pop + PW'(in_q[i]);
      end
   end

   assign maj     = (pop >= PW'(THR));
   assign in_unan = (&in_q) | ~(|in_q);

   // stab counts consecutive enabled disagreements; frozen (not cleared) while en is low
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         in_q      <= '0;
         y         <= 1'b0;
         change    <= 1'b0;
         unanimous <= 1'b0;
         stab      <= '0;
      end else if (en) begin
         in_q      <= in;
         unanimous <= in_unan;
         if (maj == y) begin
            stab   <= '0;
            change <= 1'b0;
         end else if (stab == HOLD_M1) begin
            y      <= maj;
            stab   <= '0;
            change <= 1'b1;
         end else begin
            stab   <= stab + 8'd1;
            change <= 1'b0;
         end
      end else begin
         change <= 1'b0;
      end
   end

   // clear wins over a same-edge increment; the count saturates at all-ones
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fault_count <= '0;
      end else if (clr_count) begin
         fault_count <= '0;
      end else if (en && !in_unan && (fault_count != {CW{1'b1}})) begin
         fault_count <= fault_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_majority_vote_filter.sv
// Directed bench: three voter configurations (3/4/8, 3/4/3 and 7/1/8) on a shared clock and reset.
module tb_majority_vote_filter;

   logic clock = 1'b0;
   logic reset = 1'b0;

   logic       a_en, a_clr, a_y, a_change, a_unan;
   logic [2:0] a_in;
   logic [7:0] a_fc;

   logic       b_en, b_clr, b_y, b_change, b_unan;
   logic [2:0] b_in;
   logic [2:0] b_fc;

   logic       c_en, c_clr, c_y, c_change, c_unan;
   logic [6:0] c_in;
   logic [7:0] c_fc;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   majority_vote_filter #(.N(3), .HOLD(4), .CW(8)) dut_a (
      .clock(clock), .reset(reset), .en(a_en), .in(a_in), .clr_count(a_clr),
      .y(a_y), .change(a_change), .unanimous(a_unan), .fault_count(a_fc));

   majority_vote_filter #(.N(3), .HOLD(4), .CW(3)) dut_b (
      .clock(clock), .reset(reset), .en(b_en), .in(b_in), .clr_count(b_clr),
      .y(b_y), .change(b_change), .unanimous(b_unan), .fault_count(b_fc));

   majority_vote_filter #(.N(7), .HOLD(1), .CW(8)) dut_c (
      .clock(clock), .reset(reset), .en(c_en), .in(c_in), .clr_count(c_clr),
      .y(c_y), .change(c_change), .unanimous(c_unan), .fault_count(c_fc));

   // inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      a_in = 3'b111; a_en = 1'b1; a_clr = 1'b0;
      b_in = 3'b101; b_en = 1'b1; b_clr = 1'b0;
      c_in = 7'h7f;  c_en = 1'b1; c_clr = 1'b0;

      // reset held with active inputs: nothing moves
      repeat (3) tick();
      chk("rst_y", a_y, 0);
      chk("rst_change", a_change, 0);
      chk("rst_unan", a_unan, 0);
      chk("rst_fc", a_fc, 0);
      chk("rst_b_fc", b_fc, 0);
      chk("rst_c_y", c_y, 0);

      reset = 1'b1;
      a_in = 3'b000; b_en = 1'b0; c_en = 1'b0; c_in = '0;
      tick(); tick();
      chk("base_unan", a_unan, 1);
      chk("base_y", a_y, 0);

      // majority step 000 -> 011: y rises after edge 5
      a_in = 3'b011;
      tick();
      chk("step_e1_y", a_y, 0);
      chk("step_e1_unan", a_unan, 1);
      tick();
      chk("step_e2_unan", a_unan, 0);
      chk("step_e2_fc", a_fc, 1);
      tick(); tick();
      chk("step_e4_y", a_y, 0);
      chk("step_e4_change", a_change, 0);
      chk("step_e4_fc", a_fc, 3);
      tick();
      chk("step_e5_y", a_y, 1);
      chk("step_e5_change", a_change, 1);
      chk("step_e5_fc", a_fc, 4);
      tick();
      chk("step_e6_change", a_change, 0);
      chk("step_e6_y", a_y, 1);
      chk("step_e6_fc", a_fc, 5);

      // back to 0 so the glitch test starts from y=0
      a_in = 3'b000;
      repeat (4) tick();
      chk("down_e4_y", a_y, 1);
      tick();
      chk("down_e5_y", a_y, 0);
      chk("down_e5_change", a_change, 1);
      chk("down_e5_fc", a_fc, 6);
      tick();
      chk("down_e6_change", a_change, 0);

      // three disagreeing samples reach stab=HOLD-1, then one agreeing sample restarts it
      for (int i = 0; i < 6; i++) begin
         a_in = (i < 3) ? 3'b110 : 3'b000;
         tick();
         chk("glitch_y", a_y, 0);
         chk("glitch_change", a_change, 0);
      end
      chk("glitch_fc", a_fc, 9);

      // a full persistence run afterwards needs all HOLD cycles again
      a_in = 3'b110;
      repeat (4) tick();
      chk("persist_e4_y", a_y, 0);
      tick();
      chk("persist_e5_y", a_y, 1);
      chk("persist_e5_change", a_change, 1);
      chk("persist_e5_fc", a_fc, 13);

      a_in = 3'b000;
      repeat (5) tick();
      chk("down2_y", a_y, 0);
      chk("down2_change", a_change, 1);
      chk("down2_fc", a_fc, 14);
      tick();

      // enable freeze: two disagreement cycles, five frozen, two more
      a_in = 3'b111;
      tick(); tick(); tick();
      chk("frz_pre_y", a_y, 0);
      a_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_clr = (i == 4);
         tick();
         chk("frz_y", a_y, 0);
         chk("frz_change", a_change, 0);
         chk("frz_fc", a_fc, (i == 4) ? 0 : 14);
      end
      a_clr = 1'b0;
      a_en  = 1'b1;
      tick();
      chk("frz_re1_y", a_y, 0);
      tick();
      chk("frz_re2_y", a_y, 1);
      chk("frz_re2_change", a_change, 1);

      // saturation of a 3-bit counter, then clear colliding with an increment
      b_in = 3'b101;
      b_en = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("sat_fc", b_fc, (i - 1 > 7) ? 7 : i - 1);
      end
      b_clr = 1'b1;
      tick();
      chk("sat_clr_fc", b_fc, 0);
      b_clr = 1'b0;
      tick();
      chk("sat_after_clr_fc", b_fc, 1);

      // wide config, HOLD=1: y follows the sample two edges after presentation
      c_in = 7'b0001111;
      c_en = 1'b1;
      tick();
      chk("wide_up_e1_y", c_y, 0);
      tick();
      chk("wide_up_e2_y", c_y, 1);
      chk("wide_up_e2_change", c_change, 1);
      tick();
      chk("wide_up_e3_change", c_change, 0);
      c_in = 7'b0000111;
      tick();
      chk("wide_dn_e1_y", c_y, 1);
      tick();
      chk("wide_dn_e2_y", c_y, 0);
      chk("wide_dn_e2_change", c_change, 1);

      // toggling every cycle keeps change high continuously
      c_in = 7'b1111000;
      tick();
      chk("tog_e1_change", c_change, 0);
      c_in = 7'b0000001;
      tick();
      chk("tog_e2_y", c_y, 1);
      chk("tog_e2_change", c_change, 1);
      c_in = 7'b1111111;
      tick();
      chk("tog_e3_y", c_y, 0);
      chk("tog_e3_change", c_change, 1);
      c_in = 7'b0000000;
      tick();
      chk("tog_e4_y", c_y, 1);
      chk("tog_e4_change", c_change, 1);

      // asynchronous reset clears outputs between edges
      #2 reset = 1'b0;
      #1;
      chk("arst_a_y", a_y, 0);
      chk("arst_b_fc", b_fc, 0);
      chk("arst_c_y", c_y, 0);
      chk("arst_a_unan", a_unan, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/majority_vote_filter.md
# majority_vote_filter

Parametrised N-input majority voter with a persistence filter and fault accounting. Inputs are sampled each enabled cycle, the majority is computed, and the filtered output changes only after the new majority has held for HOLD consecutive enabled cycles. It sits between redundant sensor/switch channels and downstream control logic, suppressing glitches and counting channel disagreement.

## Interface
- N, default 3: number of input channels; odd, 3..15.
- HOLD, default 4: consecutive enabled cycles of disagreement required before y flips; 1..255.
- CW, default 8: width of fault_count.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; all state cleared while low.
- en  in  1  sample/advance enable; when 0 all state holds.
- in  in  N  channel inputs; bit i is channel i.
- clr_count  in  1  synchronous clear of fault_count.
- y  out  1  filtered majority, registered.
- change  out  1  one-cycle pulse on the cycle y takes a new value, registered.
- unanimous  out  1  registered; 1 when the last sample had all channels equal.
- fault_count  out  CW  saturating count of non-unanimous enabled samples.

## Operation
- Reset (reset low, asynchronous): in_q=0, y=0, change=0, unanimous=0, stab=0, fault_count=0.
- Stage 1, on an edge with en=1: in_q <= in.
- maj = 1 when popcount(in_q) >= (N+1)/2, else 0; popcount is sized ceil(log2(N+1)) bits, with no overflow.
- Persistence counter stab is 8 bits wide. On an edge with en=1:
  - maj == y: stab <= 0, y holds, change <= 0.
  - maj != y and stab == HOLD-1: y <= maj, stab <= 0, change <= 1.
  - otherwise: stab <= stab+1, change <= 0.
- Any single enabled cycle with maj == y restarts the count.
- HOLD=1: y follows maj with no filtering beyond one register.
- unanimous, on an edge with en=1: unanimous <= (in_q all-ones or in_q all-zeros).
- fault_count, on each edge, in priority order:
  - clr_count=1: fault_count <= 0, regardless of en.
  - else, en=1 and in_q not unanimous and fault_count != all-ones: increment.
  - at all-ones: hold (saturate, never wrap).
- en=0: in_q, y, stab and unanimous hold. change <= 0. fault_count responds only to clr_count.
- clr_count and a qualifying increment on the same edge: the result is 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency, with en held high: a new majority on `in` presented before edge k is captured into in_q at edge k, and y changes at edge k+HOLD. change is high for exactly the cycle following edge k+HOLD.
- unanimous reflects the sample captured one edge earlier, i.e. it lags in by 2 edges.
- fault_count increments for the in_q sample present at that edge (in_q was captured at the previous enabled edge).
- en deasserted mid-count: stab is frozen, not cleared. The count resumes when en returns.
- reset asserted mid-count: outputs clear immediately without waiting for a clock edge. After release, the first enabled edge captures in.
- change is never high for two consecutive cycles when HOLD >= 2. With HOLD=1 and in toggling every cycle, change may be high continuously.

## Test plan
- Reset: hold reset low with in=3'b111 and en=1 -> y=0, change=0, unanimous=0, fault_count=0. No output moves until reset goes high.
- Majority step: N=3, HOLD=4, en=1, in changes 000->011 before edge 1 -> y=1 after edge 5, change high only in the cycle after edge 5. unanimous=0 from edge 2. fault_count increments from edge 2 onward while in=011.
- Glitch rejection: HOLD=4, y=0, in=110 for 3 enabled cycles, then 000 -> y stays 0, change never pulses, stab returns to 0.
- Enable freeze: in=111, en=1 for 2 edges, en=0 for 5 edges, en=1 again -> y rises 2 enabled edges after re-enable (4 enabled disagreement cycles in total). change stays 0 while en=0.
- Saturation and clear: CW=3, in=101 held with en=1 -> fault_count reaches 7 and stays at 7. Assert clr_count on an edge where an increment also qualifies -> fault_count=0 after that edge.
- Wide config: N=7, HOLD=1. in=0001111 -> y=1 two edges after presentation. in=0000111 -> y=0 two edges after presentation.
